// File: rtl/maze_pkg.sv
// Shared constants for the maze map loader: ROM address map, coordinate
// byte fields, FSM state encoding and the row/column width.
package maze_pkg;

  localparam int unsigned RC_W = 3;

  localparam logic [3:0] ADDR_ROW0  = 4'd0;
  localparam logic [3:0] ADDR_START = 4'd8;
  localparam logic [3:0] ADDR_END   = 4'd9;
  localparam logic [3:0] ADDR_LAST  = 4'd9;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_FETCH = 3'd1;
  localparam logic [2:0] ST_DRAIN = 3'd2;
  localparam logic [2:0] ST_CHECK = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  // Coordinate byte: [7:6] reserved, [5:3] row, [2:0] col
  function automatic logic [RC_W-1:0] coord_row(input logic [7:0] b);
    return b[5:3];
  endfunction

  function automatic logic [RC_W-1:0] coord_col(input logic [7:0] b);
    return b[2:0];
  endfunction

  function automatic logic [1:0] coord_rsvd(input logic [7:0] b);
    return b[7:6];
  endfunction

endpackage

// File: rtl/maze_cell_mux.sv
// Combinational wall-map lookup: returns 1 when cell (row,col) is open.
module maze_cell_mux
  import maze_pkg::*;
(
  input  logic [63:0]     map,
  input  logic [RC_W-1:0] row,
  input  logic [RC_W-1:0] col,
  output logic            cell_open
);

  // Column c lives at bit 7-c of its row byte, and 7-c equals ~c for 3 bits
  always_comb begin
    cell_open = map[{row, ~col}];
  end

endmodule

// File: rtl/maze_map_loader.sv
// Loads a maze map from an external synchronous ROM (addresses 0..9),
// captures the wall map plus start/end records, and validates them.
module maze_map_loader
  import maze_pkg::*;
#(
  parameter int unsigned NUM_MAPS = 4,
  parameter int unsigned SEL_W    = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [SEL_W-1:0] map_sel,
  output logic             busy,
  output logic             ready,
  output logic             err,
  output logic [SEL_W-1:0] rom_sel,
  output logic             rom_en,
  output logic [3:0]       rom_addr,
  input  logic [7:0]       rom_data,
  output logic [63:0]      maze_map,
  output logic [2:0]       start_row,
  output logic [2:0]       start_col,
  output logic [2:0]       end_row,
  output logic [2:0]       end_col,
  input  logic [2:0]       q_row,
  input  logic [2:0]       q_col,
  output logic             q_open
);

  if (NUM_MAPS > (1 << SEL_W)) begin : g_sel_check
    $error("map_sel is too narrow for NUM_MAPS");
  end

  logic [2:0] state;
  logic       cap_en;
  logic [3:0] cap_addr;
  logic [7:0] start_byte;
  logic [7:0] end_byte;
  logic       start_open;
  logic       end_open;
  logic       q_cell_open;
  logic       check_fail;

  // Sequencer: accepts load in IDLE/DONE, walks ROM addresses, then validates
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      busy     <= 1'b0;
      ready    <= 1'b0;
      err      <= 1'b0;
      rom_sel  <= '0;
      rom_en   <= 1'b0;
      rom_addr <= ADDR_ROW0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (load) begin
            state    <= ST_FETCH;
            busy     <= 1'b1;
            ready    <= 1'b0;
            err      <= 1'b0;
            rom_sel  <= map_sel;
            rom_en   <= 1'b1;
            rom_addr <= ADDR_ROW0;
          end
        end
        ST_FETCH: begin
          if (rom_addr == ADDR_LAST) begin
            rom_en   <= 1'b0;
            rom_addr <= ADDR_ROW0;
            state    <= ST_DRAIN;
          end else begin
            rom_addr <= rom_addr + 4'd1;
          end
        end
        ST_DRAIN: begin
          state <= ST_CHECK;
        end
        ST_CHECK: begin
          err   <= check_fail;
          ready <= 1'b1;
          busy  <= 1'b0;
          state <= ST_DONE;
        end
        default: begin
          state    <= ST_IDLE;
          busy     <= 1'b0;
          ready    <= 1'b0;
          err      <= 1'b0;
          rom_en   <= 1'b0;
          rom_addr <= ADDR_ROW0;
        end
      endcase
    end
  end

  // Capture pipeline: ROM data arrives one cycle after its address was sampled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_en     <= 1'b0;
      cap_addr   <= '0;
      maze_map   <= '0;
      start_byte <= '0;
      end_byte   <= '0;
    end else begin
      cap_en   <= rom_en;
      cap_addr <= rom_addr;
      if (cap_en) begin
        if (cap_addr < ADDR_START) begin
          maze_map[{cap_addr[2:0], 3'b000} +: 8] <= rom_data;
        end else if (cap_addr == ADDR_START) begin
          start_byte <= rom_data;
        end else if (cap_addr == ADDR_END) begin
          end_byte <= rom_data;
        end
      end
    end
  end

  maze_cell_mux u_start_mux (
    .map       (maze_map),
    .row       (coord_row(start_byte)),
    .col       (coord_col(start_byte)),
    .cell_open (start_open)
  );

  maze_cell_mux u_end_mux (
    .map       (maze_map),
    .row       (coord_row(end_byte)),
    .col       (coord_col(end_byte)),
    .cell_open (end_open)
  );

  maze_cell_mux u_query_mux (
    .map       (maze_map),
    .row       (q_row),
    .col       (q_col),
    .cell_open (q_cell_open)
  );

  // Validation of the captured start/end records and query gating
  always_comb begin
    check_fail = (coord_rsvd(start_byte) != 2'b00)
               | (coord_rsvd(end_byte) != 2'b00)
               | ~start_open
               | ~end_open
               | (start_byte == end_byte);
    q_open     = ready & q_cell_open;
    start_row  = coord_row(start_byte);
    start_col  = coord_col(start_byte);
    end_row    = coord_row(end_byte);
    end_col    = coord_col(end_byte);
  end

endmodule
